// File: rtl/bias_add_pkg.sv
// Shared definitions for the bias-add block: the control FSM state
// encoding and the width-generic per-lane saturating adder.
package bias_add_pkg;

    // Widest lane the saturating adder supports (lane width must stay below this).
    localparam int SAT_MAX_W = 128;

    typedef logic signed [SAT_MAX_W-1:0] sat_word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    // Adds two sign-extended operands and clamps the result to the signed
    // range of a w-bit word. Operands must already be sign-extended from w
    // bits, so the wide sum can never wrap.
    function automatic sat_word_t sat_add(input sat_word_t a, input sat_word_t b, input int w);
        sat_word_t sum;
        sat_word_t hi;
        sat_word_t lo;
        sum = a + b;
        hi  = (sat_word_t'(1) << (w - 1)) - sat_word_t'(1);
        lo  = ~hi;
        if (sum > hi) begin
            sat_add = hi;
        end else if (sum < lo) begin
            sat_add = lo;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/bias_add_if.sv
// Bus bundle for bias_add: job control, accumulator input stream, bias RAM
// read port and biased output stream. slave = the bias_add block,
// master = whatever drives it.
interface bias_add_if #(
    parameter int pWEIGHT_DATA_WIDTH = 64,
    parameter int pBLOCK_RAM_NUM     = 32,
    parameter int pBIAS_NUM          = 32
);
    localparam int DW = pWEIGHT_DATA_WIDTH * pBLOCK_RAM_NUM;
    localparam int AW = $clog2(pBIAS_NUM);
    localparam int GW = AW + 1;

    logic          start;
    logic [GW-1:0] cfg_grp_num;
    logic [15:0]   cfg_pix_num;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    logic [AW-1:0] bias_addr;
    logic [DW-1:0] bias_data;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    logic          busy;
    logic          done;

    modport slave (
        input  start, cfg_grp_num, cfg_pix_num,
        input  in_valid, in_data,
        output in_ready,
        output bias_addr,
        input  bias_data,
        output out_valid, out_data, out_last,
        input  out_ready,
        output busy, done
    );

    modport master (
        output start, cfg_grp_num, cfg_pix_num,
        output in_valid, in_data,
        input  in_ready,
        input  bias_addr,
        output bias_data,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  busy, done
    );
endinterface

// File: rtl/bias_add_lane.sv
// One lane of the bias adder: signed saturating add of accumulator and bias.
module bias_add_lane
    import bias_add_pkg::*;
#(
    parameter int pLANE_WIDTH = 64
) (
    input  logic [pLANE_WIDTH-1:0] a_i,
    input  logic [pLANE_WIDTH-1:0] b_i,
    output logic [pLANE_WIDTH-1:0] y_o
);
    logic signed [pLANE_WIDTH-1:0] a_s;
    logic signed [pLANE_WIDTH-1:0] b_s;

    assign a_s = a_i;
    assign b_s = b_i;

    // Operands are sign-extended into the wide word; the clamped result fits
    // back into pLANE_WIDTH bits by construction.
    assign y_o = pLANE_WIDTH'(sat_add(sat_word_t'(a_s), sat_word_t'(b_s), pLANE_WIDTH));
endmodule

// File: rtl/bias_add.sv
// Bias adder: streams pix_num accumulator beats per channel group, adding the
// group's bias word (read once per group from an external registered RAM)
// to every lane with signed saturation. One output register, 1-cycle latency.
module bias_add
    import bias_add_pkg::*;
#(
    parameter int pWEIGHT_DATA_WIDTH = 64,
    parameter int pBLOCK_RAM_NUM     = 32,
    parameter int pBIAS_NUM          = 32
) (
    input  logic        clk,
    input  logic        rst,
    bias_add_if.slave   bus
);
    localparam int W  = pWEIGHT_DATA_WIDTH;
    localparam int DW = pWEIGHT_DATA_WIDTH * pBLOCK_RAM_NUM;
    localparam int AW = $clog2(pBIAS_NUM);
    localparam int GW = AW + 1;

    state_e        state_q, state_d;
    logic [GW-1:0] grp_num_q, grp_num_d;
    logic [GW-1:0] grp_cnt_q, grp_cnt_d;
    logic [15:0]   pix_num_q, pix_num_d;
    logic [15:0]   pix_cnt_q, pix_cnt_d;
    logic [DW-1:0] bias_q, bias_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          done_q, done_d;

    logic [DW-1:0] sum_w;
    logic          in_ready_w;
    logic          accept_w;
    logic          last_pix_w;
    logic          last_grp_w;

    genvar gi;
    generate
        for (gi = 0; gi < pBLOCK_RAM_NUM; gi++) begin : g_lane
            bias_add_lane #(
                .pLANE_WIDTH(W)
            ) u_lane (
                .a_i(bus.in_data[gi*W +: W]),
                .b_i(bias_q[gi*W +: W]),
                .y_o(sum_w[gi*W +: W])
            );
        end
    endgenerate

    // Input is taken only while running and the output register can move.
    assign in_ready_w = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    assign accept_w   = bus.in_valid && in_ready_w;
    assign last_pix_w = (pix_cnt_q == pix_num_q - 16'd1);
    assign last_grp_w = (grp_cnt_q == grp_num_q - GW'(1));

    // Next-state, counters and output register; hold everything by default.
    always_comb begin
        state_d     = state_q;
        grp_num_d   = grp_num_q;
        grp_cnt_d   = grp_cnt_q;
        pix_num_d   = pix_num_q;
        pix_cnt_d   = pix_cnt_q;
        bias_d      = bias_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        if (accept_w) begin
            out_valid_d = 1'b1;
            out_data_d  = sum_w;
            out_last_d  = last_pix_w && last_grp_w;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    grp_num_d = bus.cfg_grp_num;
                    pix_num_d = bus.cfg_pix_num;
                    grp_cnt_d = '0;
                    pix_cnt_d = '0;
                    if ((bus.cfg_grp_num == '0) || (bus.cfg_pix_num == '0)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                bias_d  = bus.bias_data;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept_w) begin
                    if (last_pix_w) begin
                        pix_cnt_d = '0;
                        grp_cnt_d = grp_cnt_q + GW'(1);
                        state_d   = last_grp_w ? ST_FIN : ST_FETCH;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 16'd1;
                    end
                end
            end
            ST_FIN: begin
                if (!out_valid_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any job and any held output beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grp_num_q   <= '0;
            grp_cnt_q   <= '0;
            pix_num_q   <= '0;
            pix_cnt_q   <= '0;
            bias_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_num_q   <= grp_num_d;
            grp_cnt_q   <= grp_cnt_d;
            pix_num_q   <= pix_num_d;
            pix_cnt_q   <= pix_cnt_d;
            bias_q      <= bias_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // The group counter only moves on a group's last accepted beat, so the
    // address is stable from FETCH through the whole group.
    assign bus.bias_addr = grp_cnt_q[AW-1:0];
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
endmodule
